// File: rtl/image_sequencer.sv
// Frame sequencer: per A-line fetch delays, fire num_avg shots, wait for memory drain, loop frames.
// All outputs registered (Moore); abort returns to IDLE on the next edge, a transmit watchdog raises a sticky error.
module image_sequencer #(
  parameter int ALINE_W     = 6,
  parameter int AVG_W       = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FCNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [ALINE_W-1:0] num_alines,
  input  logic [AVG_W-1:0]   num_avg,
  input  logic               cfg_valid,
  output logic               fetch_req,
  output logic [ALINE_W-1:0] fetch_aline,
  input  logic               fetch_done,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic               tx_done,
  input  logic               mem_clear,
  output logic               busy,
  output logic [ALINE_W-1:0] current_aline,
  output logic [AVG_W-1:0]   current_shot,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               aborted,
  output logic               error,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    FIRE    = 3'd2,
    WAIT_TX = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t             st;
  logic [ALINE_W-1:0] n_lat;
  logic [AVG_W-1:0]   avg_lat;
  logic [WD_W-1:0]    wd;

  // One extra bit so a full-scale count never wraps in the compare.
  logic [ALINE_W:0] aline_nxt;
  logic [AVG_W:0]   shot_nxt;
  assign aline_nxt = {1'b0, current_aline} + (ALINE_W+1)'(1);
  assign shot_nxt  = {1'b0, current_shot} + (AVG_W+1)'(1);

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      n_lat         <= '0;
      avg_lat       <= '0;
      wd            <= '0;
      fetch_req     <= 1'b0;
      fetch_aline   <= '0;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
      current_aline <= '0;
      current_shot  <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      aborted       <= 1'b0;
      error         <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      if (st != IDLE && abort) begin
        st        <= IDLE;
        aborted   <= 1'b1;
        fetch_req <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (start && cfg_valid && !tx_busy && num_alines != '0) begin
              n_lat         <= num_alines;
              avg_lat       <= (num_avg == '0) ? AVG_W'(1) : num_avg;
              current_aline <= '0;
              current_shot  <= '0;
              error         <= 1'b0;
              fetch_aline   <= '0;
              fetch_req     <= 1'b1;
              busy          <= 1'b1;
              st            <= FETCH;
            end
          end
          FETCH: begin
            if (fetch_done) begin
              fetch_req <= 1'b0;
              tx_start  <= 1'b1;
              st        <= FIRE;
            end
          end
          FIRE: begin
            wd <= WD_W'(TIMEOUT_CYC);
            st <= WAIT_TX;
          end
          WAIT_TX: begin
            wd <= wd - WD_W'(1);
            if (tx_done) begin
              st <= DRAIN;
            end else if (wd == WD_W'(1)) begin
              error <= 1'b1;
              busy  <= 1'b0;
              st    <= IDLE;
            end
          end
          DRAIN: begin
            if (mem_clear) begin
              if (shot_nxt < {1'b0, avg_lat}) begin
                // Same A-line: delays already loaded, so fire again directly.
                current_shot <= shot_nxt[AVG_W-1:0];
                tx_start     <= 1'b1;
                st           <= FIRE;
              end else if (aline_nxt < {1'b0, n_lat}) begin
                current_shot  <= '0;
                current_aline <= aline_nxt[ALINE_W-1:0];
                fetch_aline   <= aline_nxt[ALINE_W-1:0];
                fetch_req     <= 1'b1;
                st            <= FETCH;
              end else begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + FCNT_W'(1);
                if (continuous) begin
                  current_shot  <= '0;
                  current_aline <= '0;
                  fetch_aline   <= '0;
                  fetch_req     <= 1'b1;
                  st            <= FETCH;
                end else begin
                  busy <= 1'b0;
                  st   <= IDLE;
                end
              end
            end
          end
          default: begin
            busy <= 1'b0;
            st   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_sequencer.sv
// Directed bench for image_sequencer; auto-responders model config storage and transmitter.
module tb_image_sequencer;
  localparam int AW = 6;
  localparam int VW = 4;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, continuous, cfg_valid, tx_busy, mem_clear;
  logic [AW-1:0] num_alines;
  logic [VW-1:0] num_avg;
  logic          fetch_req, fetch_done, tx_start, tx_done, busy, frame_done, aborted, error;
  logic [AW-1:0] fetch_aline, current_aline;
  logic [VW-1:0] current_shot;
  logic [FW-1:0] frame_count;
  logic [2:0]    state;

  logic fd_auto = 1'b0, td_auto = 1'b0, fd_man = 1'b0, td_man = 1'b0;
  logic auto_fetch = 1'b0, auto_tx = 1'b0;
  assign fetch_done = fd_auto | fd_man;
  assign tx_done    = td_auto | td_man;

  int n_total = 0;
  int n_pass  = 0;

  image_sequencer #(.ALINE_W(AW), .AVG_W(VW), .TIMEOUT_CYC(8), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .num_alines(num_alines), .num_avg(num_avg), .cfg_valid(cfg_valid),
    .fetch_req(fetch_req), .fetch_aline(fetch_aline), .fetch_done(fetch_done),
    .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done), .mem_clear(mem_clear),
    .busy(busy), .current_aline(current_aline), .current_shot(current_shot),
    .frame_done(frame_done), .frame_count(frame_count), .aborted(aborted),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  // Environment: fetch_done 3 cycles into a request, tx_done 3 cycles after tx_start.
  int fwait = 0, twait = 0;
  always @(negedge clk) begin
    fd_auto = 1'b0;
    td_auto = 1'b0;
    if (auto_fetch && fetch_req) begin
      fwait++;
      if (fwait == 3) begin fd_auto = 1'b1; fwait = 0; end
    end else fwait = 0;
    if (auto_tx && tx_start) twait = 1;
    else if (twait != 0) begin
      twait++;
      if (twait == 3) begin td_auto = 1'b1; twait = 0; end
    end
  end

  // Event counters sampled mid-cycle.
  int cnt_fetch = 0, cnt_tx = 0, cnt_fd = 0;
  logic prev_fr = 1'b0;
  logic [31:0] aline_log = '0;
  always @(negedge clk) begin
    if (fetch_req && !prev_fr) cnt_fetch++;
    prev_fr = fetch_req;
    if (tx_start) begin
      cnt_tx++;
      aline_log = {aline_log[27:0], current_aline[3:0]};
    end
    if (frame_done) cnt_fd++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_start(input int n, input int avg);
    num_alines = n[AW-1:0];
    num_avg    = avg[VW-1:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int k = 0;
    while (state !== s && k < max) begin tick(); k++; end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    int f0, t0, d0, held, k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    cfg_valid = 1'b1; tx_busy = 1'b0; mem_clear = 1'b1;
    num_alines = '0; num_avg = '0;
    tick(); tick();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outs", {busy, fetch_req, tx_start, frame_done, aborted, error}, 32'd0);
    check("rst_fcnt", {16'd0, frame_count}, 32'd0);
    rst = 1'b0;
    tick();

    // 3 A-lines x 2 shots
    auto_fetch = 1'b1; auto_tx = 1'b1;
    f0 = cnt_fetch; t0 = cnt_tx; d0 = cnt_fd;
    do_start(3, 2);
    check("start_lat_state", {29'd0, state}, 32'd1);
    check("start_lat_freq", {31'd0, fetch_req}, 32'd1);
    wait_state(3'd0, 300, "f1_idle");
    check("f1_fetches", cnt_fetch - f0, 32'd3);
    check("f1_txstarts", cnt_tx - t0, 32'd6);
    check("f1_alines", {8'd0, aline_log[23:0]}, 32'h0000_1122);
    check("f1_frames", cnt_fd - d0, 32'd1);
    check("f1_fcnt", {16'd0, frame_count}, 32'd1);

    // num_avg=0 behaves as one shot
    t0 = cnt_tx; d0 = cnt_fd;
    do_start(1, 0);
    wait_state(3'd0, 100, "avg0_idle");
    check("avg0_txstarts", cnt_tx - t0, 32'd1);
    check("avg0_frames", cnt_fd - d0, 32'd1);
    check("avg0_fcnt", {16'd0, frame_count}, 32'd2);
    do_start(0, 1);
    tick();
    check("n0_state", {29'd0, state}, 32'd0);
    check("n0_busy", {31'd0, busy}, 32'd0);

    // watchdog expiry with TIMEOUT_CYC=8
    auto_tx = 1'b0;
    d0 = cnt_fd;
    do_start(1, 1);
    k = 0;
    while (tx_start !== 1'b1 && k < 50) begin tick(); k++; end
    check("wd_txstart_seen", {31'd0, tx_start}, 32'd1);
    repeat (7) tick();
    check("wd_pre_state", {29'd0, state}, 32'd3);
    check("wd_pre_err", {31'd0, error}, 32'd0);
    tick(); tick();
    check("wd_err", {31'd0, error}, 32'd1);
    check("wd_state", {29'd0, state}, 32'd0);
    check("wd_busy", {31'd0, busy}, 32'd0);
    check("wd_noframe", cnt_fd - d0, 32'd0);
    tick();
    check("wd_sticky", {31'd0, error}, 32'd1);
    auto_tx = 1'b1;
    do_start(1, 1);
    check("wd_clear", {31'd0, error}, 32'd0);
    wait_state(3'd0, 100, "wd_rerun_idle");
    check("wd_rerun_fcnt", {16'd0, frame_count}, 32'd3);

    // continuous frames, dropped during the third
    continuous = 1'b1;
    f0 = cnt_fetch; d0 = cnt_fd;
    do_start(2, 1);
    k = 0;
    while ((cnt_fd - d0) < 2 && k < 500) begin tick(); k++; end
    check("cont_two_frames", cnt_fd - d0, 32'd2);
    continuous = 1'b0;
    wait_state(3'd0, 300, "cont_idle");
    check("cont_frames", cnt_fd - d0, 32'd3);
    check("cont_fcnt", {16'd0, frame_count}, 32'd6);
    check("cont_fetches", cnt_fetch - f0, 32'd6);

    // abort in WAIT_TX colliding with tx_done
    auto_fetch = 1'b0; auto_tx = 1'b0;
    d0 = cnt_fd;
    do_start(1, 1);
    check("ab_fetch", {29'd0, state}, 32'd1);
    fd_man = 1'b1;
    tick();
    fd_man = 1'b0;
    check("ab_fire", {29'd0, state, tx_start}, {28'd0, 3'd2, 1'b1});
    tick();
    check("ab_wait", {29'd0, state}, 32'd3);
    abort = 1'b1; td_man = 1'b1;
    tick();
    abort = 1'b0; td_man = 1'b0;
    check("ab_state", {29'd0, state}, 32'd0);
    check("ab_pulse", {31'd0, aborted}, 32'd1);
    check("ab_outs", {busy, tx_start, fetch_req}, 32'd0);
    check("ab_fcnt", {16'd0, frame_count}, 32'd6);
    tick();
    check("ab_after", {state, aborted}, 32'd0);
    check("ab_noframe", cnt_fd - d0, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_noeffect", {31'd0, aborted}, 32'd0);

    // start gating
    cfg_valid = 1'b0;
    do_start(2, 1);
    check("gate_cfg", {28'd0, state, busy}, 32'd0);
    cfg_valid = 1'b1; tx_busy = 1'b1;
    do_start(2, 1);
    check("gate_txbusy", {28'd0, state, busy}, 32'd0);
    tx_busy = 1'b0;

    // DRAIN holds while memory is not clear
    auto_fetch = 1'b1; auto_tx = 1'b1; mem_clear = 1'b0;
    do_start(1, 1);
    wait_state(3'd4, 50, "drain_enter");
    held = 0;
    repeat (20) begin tick(); if (state === 3'd4) held++; end
    check("drain_hold", held, 32'd20);
    mem_clear = 1'b1;
    tick();
    check("drain_exit", {28'd0, state, frame_done}, 32'd1);
    check("drain_fcnt", {16'd0, frame_count}, 32'd7);

    // reset mid-frame
    do_start(3, 2);
    wait_state(3'd3, 50, "mid_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", {28'd0, state, busy}, 32'd0);
    check("mid_rst_fcnt", {16'd0, frame_count}, 32'd0);
    check("mid_rst_err", {31'd0, error}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
